// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multiply/divide unit with HI/LO registers for a 5-stage MIPS pipeline.
//
// Launches MULT/MULTU/DIV/DIVU from the E stage and keeps busy high for a fixed
// number of cycles (MULT_CYCLES or DIV_CYCLES). The result is written to HI/LO
// on the completion edge. MTHI/MTLO write HI/LO directly, with no busy cycles.
// mfhi/mflo read HI/LO straight from the ports; there is no internal forwarding.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (default 5)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (default 10)
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-high reset
//   start  in   1   single-cycle launch pulse from E
//   op     in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   A      in  32   rs operand (forwarded)
//   B      in  32   rt operand (forwarded)
//   busy   out  1   operation in flight
//   HI     out 32   HI register
//   LO     out 32   LO register
// -----------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  // A zero cycle count would never reach the completion value, so clamp to 1.
  localparam int MULT_LOAD  = (MULT_CYCLES < 1) ? 1 : MULT_CYCLES;
  localparam int DIV_LOAD   = (DIV_CYCLES < 1) ? 1 : DIV_CYCLES;
  localparam int MAX_CYCLES = (MULT_LOAD > DIV_LOAD) ? MULT_LOAD : DIV_LOAD;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  op_e              op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  // Result datapath, evaluated from the operands latched at launch so that
  // later changes on A/B cannot disturb an operation in flight. Divide by zero
  // and the INT_MIN / -1 overflow case are given fixed architectural results.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    res_hi = HI;
    res_lo = LO;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (b_q == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = a_q;
        end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $signed(a_q) / $signed(b_q);
          res_hi = $signed(a_q) % $signed(b_q);
        end
      end
      OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_lo = 32'hFFFF_FFFF;
          res_hi = a_q;
        end else begin
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
      default: begin
        res_hi = HI;
        res_lo = LO;
      end
    endcase
  end

  // Control and HI/LO state. While busy, every start is ignored, which also
  // covers a start arriving on the very edge busy falls. The counter is loaded
  // with N at launch and the result is committed on the edge it would reach 0,
  // giving exactly N busy cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= OP_NONE;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      HI   <= 32'd0;
      LO   <= 32'd0;
    end else if (busy) begin
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        cnt  <= '0;
        HI   <= res_hi;
        LO   <= res_lo;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (start) begin
      case (op_e'(op))
        OP_MULT, OP_MULTU: begin
          op_q <= op_e'(op);
          a_q  <= A;
          b_q  <= B;
          cnt  <= CNT_W'(MULT_LOAD);
          busy <= 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          op_q <= op_e'(op);
          a_q  <= A;
          b_q  <= B;
          cnt  <= CNT_W'(DIV_LOAD);
          busy <= 1'b1;
        end
        OP_MTHI: HI <= A;
        OP_MTLO: LO <= A;
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu. Each scenario is a task that drives
// the DUT and compares against a behavioural model of HI/LO arithmetic built on
// 64-bit integer math.
// -----------------------------------------------------------------------------
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  // Reference: returns {HI,LO} after op, given the previous HI/LO.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ph,
                                        input logic [31:0] pl);
    int          sa;
    int          sb;
    longint      q;
    longint      r;
    logic [63:0] res;
    sa  = a;
    sb  = b;
    res = {ph, pl};
    case (o)
      3'd1: res = 64'(longint'(sa) * longint'(sb));
      3'd2: res = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q   = longint'(sa) / longint'(sb);
          r   = longint'(sa) - q * longint'(sb);
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      3'd5: res = {a, pl};
      3'd6: res = {ph, a};
      default: res = {ph, pl};
    endcase
    return res;
  endfunction

  function automatic int cycles_for(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return MC;
    if (o == 3'd3 || o == 3'd4) return DC;
    return 0;
  endfunction

  // Launch one operation, scramble A/B while busy, then check latency,
  // HI/LO hold during busy, and the final HI/LO.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    logic [31:0] ph;
    logic [31:0] pl;
    logic [63:0] exp;
    int          n;
    bit          hold_bad;
    @(negedge clk);
    ph    = HI;
    pl    = LO;
    exp   = model(o, a, b, ph, pl);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start    = 1'b0;
    op       = 3'd0;
    A        = $urandom;
    B        = $urandom;
    n        = 0;
    hold_bad = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (HI !== ph || LO !== pl) hold_bad = 1'b1;
      @(negedge clk);
      A = $urandom;
      B = $urandom;
    end
    checks++;
    if (n !== cycles_for(o)) begin
      errors++;
      $display("[TB] FAIL %s busy_cycles got %0d expected %0d", name, n, cycles_for(o));
    end
    if (cycles_for(o) > 0) begin
      checks++;
      if (hold_bad !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s hold_during_busy got changed expected held %h/%h", name, ph, pl);
      end
    end
    checks++;
    if (HI !== exp[63:32]) begin
      errors++;
      $display("[TB] FAIL %s HI got %h expected %h", name, HI, exp[63:32]);
    end
    checks++;
    if (LO !== exp[31:0]) begin
      errors++;
      $display("[TB] FAIL %s LO got %h expected %h", name, LO, exp[31:0]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO);
    end
    // First start right after deassertion must be taken on the next edge.
    reset = 1'b0;
    start = 1'b1;
    op    = 3'd6;
    A     = 32'h0000_CAFE;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    checks++;
    if (LO !== 32'h0000_CAFE || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_start_after_reset got LO=%h busy=%b expected 0000cafe/0", LO, busy);
    end
  endtask

  task automatic test_mult;
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    do_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu_neg2x3");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mult_min_sq");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max_sq");
  endtask

  task automatic test_div;
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(3'd4, 32'd7, 32'd2, "divu_7_2");
    do_op(3'd4, 32'd5, 32'd0, "divu_by_zero");
    do_op(3'd3, 32'hFFFF_FFFB, 32'd0, "div_by_zero");
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    do_op(3'd3, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
  endtask

  task automatic test_ignore_busy;
    logic [63:0] exp;
    int          n;
    @(negedge clk);
    exp   = model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, HI, LO);
    start = 1'b1;
    op    = 3'd1;
    A     = 32'h1234_5678;
    B     = 32'h9ABC_DEF0;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 2) begin
        start = 1'b1;
        op    = 3'd5;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0;
      end else begin
        start = 1'b0;
        op    = 3'd0;
        A     = $urandom;
        B     = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    op    = 3'd0;
    checks++;
    if (n !== MC) begin
      errors++;
      $display("[TB] FAIL ignore_busy busy_cycles got %0d expected %0d", n, MC);
    end
    checks++;
    if (HI !== exp[63:32] || LO !== exp[31:0]) begin
      errors++;
      $display("[TB] FAIL ignore_busy result got %h_%h expected %h", HI, LO, exp);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || HI !== exp[63:32]) begin
      errors++;
      $display("[TB] FAIL ignore_busy no_relaunch got busy=%b HI=%h expected 0/%h", busy, HI, exp[63:32]);
    end
  endtask

  task automatic test_reset_mid;
    do_op(3'd5, 32'h1111_1111, 32'd0, "pre_mthi");
    do_op(3'd6, 32'h2222_2222, 32'd0, "pre_mtlo");
    @(negedge clk);
    start = 1'b1;
    op    = 3'd3;
    A     = 32'd100;
    B     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid immediate got busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid no_late_write got busy=%b HI=%h LO=%h expected 0/0/0", busy, HI, LO);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp;
    do_op(3'd6, 32'h0000_1234, 32'd0, "mtlo_1234");
    @(negedge clk);
    exp   = model(3'd1, 32'h0000_0101, 32'h0000_0202, HI, LO);
    start = 1'b1;
    op    = 3'd1;
    A     = 32'h0000_0101;
    B     = 32'h0000_0202;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    repeat (MC - 1) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b last_busy_cycle got busy=%b expected 1", busy);
    end
    // Start held over the edge where busy falls: must be ignored.
    start = 1'b1;
    op    = 3'd5;
    A     = 32'h55AA_55AA;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || HI !== exp[63:32] || LO !== exp[31:0]) begin
      errors++;
      $display("[TB] FAIL b2b falling_edge_start got busy=%b %h_%h expected 0/%h", busy, HI, LO, exp);
    end
    // Start one cycle later: accepted.
    op = 3'd6;
    A  = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    checks++;
    if (LO !== 32'h0BAD_F00D || HI !== exp[63:32] || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b next_cycle_start got busy=%b %h_%h expected 0/%h_0badf00d", busy, HI, LO, exp[63:32]);
    end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      do_op(o, a, b, "random_op");
    end
  endtask

  initial begin
    $display("[TB] mdu bench starting");
    test_reset();
    test_mult();
    test_div();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
